// File: rtl/cond_gate.sv
// cond_gate: ARM condition-code evaluation stage. Flags are bypassed from the
// CPSR write port, older flag writers interlock the stage, one output register.
module cond_gate #(
  parameter int PAYLOADW = 32,
  parameter int FLAGSW   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_cond,
  input  logic [FLAGSW-1:0]   in_setmask,
  input  logic [PAYLOADW-1:0] in_payload,
  input  logic [FLAGSW-1:0]   cpsr_flags,
  input  logic [FLAGSW-1:0]   wb_setmask,
  input  logic [FLAGSW-1:0]   wb_flags,
  input  logic                flags_pending,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_exec,
  output logic [FLAGSW-1:0]   out_setmask,
  output logic [PAYLOADW-1:0] out_payload,
  output logic [15:0]         stall_count
);

  // Handshake: a beat moves across a port on a rising edge where valid and
  // ready are both high; valid never waits on ready, and a held beat keeps
  // its data stable until it is taken (or squashed by flush).
  logic [FLAGSW-1:0] eff;
  logic              flag_v, flag_c, flag_z, flag_n;
  logic              pass;
  logic              interlock;
  logic              xfer;

  assign eff    = (wb_setmask & wb_flags) | (~wb_setmask & cpsr_flags);
  assign flag_v = eff[0];
  assign flag_c = eff[1];
  assign flag_z = eff[2];
  assign flag_n = eff[3];

  always_comb begin
    pass = 1'b0;
    unique case (in_cond)
      4'd0:  pass = flag_z;
      4'd1:  pass = !flag_z;
      4'd2:  pass = flag_c;
      4'd3:  pass = !flag_c;
      4'd4:  pass = flag_n;
      4'd5:  pass = !flag_n;
      4'd6:  pass = flag_v;
      4'd7:  pass = !flag_v;
      4'd8:  pass = flag_c && !flag_z;
      4'd9:  pass = !flag_c || flag_z;
      4'd10: pass = (flag_n == flag_v);
      4'd11: pass = (flag_n != flag_v);
      4'd12: pass = !flag_z && (flag_n == flag_v);
      4'd13: pass = flag_z || (flag_n != flag_v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // AL does not read flags, so it may proceed past a pending flag writer.
  assign interlock = in_valid && flags_pending && (in_cond != 4'd14);
  assign in_ready  = (!out_valid || out_ready) && !interlock;
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_exec    <= 1'b0;
      out_setmask <= '0;
      out_payload <= '0;
      stall_count <= 16'd0;
    end else begin
      if (flush) begin
        out_valid   <= 1'b0;
        out_setmask <= '0;
      end else if (xfer) begin
        out_valid   <= 1'b1;
        out_exec    <= pass;
        out_setmask <= in_setmask & {FLAGSW{pass}};
        out_payload <= in_payload;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end

      if (interlock && !flush && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cond_gate.sv
// Testbench for cond_gate: table vectors, exhaustive cond x flags sweep and
// hand-written interlock, backpressure, flush and reset sequences.
module tb_cond_gate;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [3:0]  in_setmask;
  logic [31:0] in_payload;
  logic [3:0]  cpsr_flags;
  logic [3:0]  wb_setmask;
  logic [3:0]  wb_flags;
  logic        flags_pending;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_exec;
  logic [3:0]  out_setmask;
  logic [31:0] out_payload;
  logic [15:0] stall_count;

  cond_gate #(.PAYLOADW(32), .FLAGSW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_setmask(in_setmask), .in_payload(in_payload),
    .cpsr_flags(cpsr_flags), .wb_setmask(wb_setmask), .wb_flags(wb_flags),
    .flags_pending(flags_pending), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_exec(out_exec),
    .out_setmask(out_setmask), .out_payload(out_payload),
    .stall_count(stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: entries are {exec, setmask, payload}
  logic [36:0] exp_q[$];
  logic [15:0] m_stall;
  int          total;
  int          passed;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // independent reference: flags f = {N,Z,C,V}
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic v, c, z, n;
    v = f[0]; c = f[1]; z = f[2]; n = f[3];
    case (cond)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return c;
      4'd3:  return ~c;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return c & ~z;
      4'd9:  return ~c | z;
      4'd10: return ~(n ^ v);
      4'd11: return n ^ v;
      4'd12: return ~z & ~(n ^ v);
      4'd13: return z | (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one clock: entered and left at posedge+1
  task automatic cycle(input logic iv, input logic [3:0] cond, input logic [3:0] sm,
                       input logic [31:0] pl, input logic [3:0] cpsr,
                       input logic [3:0] wbm, input logic [3:0] wbf,
                       input logic pend, input logic fl, input logic ordy,
                       input logic exp_exec);
    logic ilk, exp_rdy, m_valid, do_xfer;
    in_valid = iv; in_cond = cond; in_setmask = sm; in_payload = pl;
    cpsr_flags = cpsr; wb_setmask = wbm; wb_flags = wbf;
    flags_pending = pend; flush = fl; out_ready = ordy;
    m_valid = (exp_q.size() != 0);
    ilk     = iv && pend && (cond != 4'd14);
    exp_rdy = (!m_valid || ordy) && !ilk;
    do_xfer = iv && exp_rdy;
    #4;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (m_valid && ordy) void'(exp_q.pop_front());
      if (do_xfer) exp_q.push_back({exp_exec, sm & {4{exp_exec}}, pl});
    end
    if (ilk && !fl && m_stall != 16'hFFFF) m_stall++;
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_exec", out_exec, exp_q[0][36]);
      chk("out_setmask", out_setmask, exp_q[0][35:32]);
      chk("out_payload", out_payload, exp_q[0][31:0]);
    end
    chk("stall_count", stall_count, m_stall);
  endtask

  task automatic idle();
    cycle(1'b0, 4'd14, 4'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [3:0] cond;
    logic [3:0] cpsr;
    logic [3:0] wbm;
    logic [3:0] wbf;
    logic [3:0] sm;
    logic       exp;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [3:0] wbm, r1, r2, cpsr, wbf;
    logic [31:0] pl;
    total = 0; passed = 0; m_stall = 16'd0;

    vt[0] = '{4'd0,  4'b0100, 4'b0000, 4'b0000, 4'hF, 1'b1}; // EQ with Z set
    vt[1] = '{4'd0,  4'b0100, 4'b0100, 4'b0000, 4'hF, 1'b0}; // bypass clears Z
    vt[2] = '{4'd1,  4'b0000, 4'b0100, 4'b0100, 4'h3, 1'b0}; // bypass sets Z, NE fails
    vt[3] = '{4'd8,  4'b0010, 4'b0000, 4'b0000, 4'h5, 1'b1}; // HI: C & !Z
    vt[4] = '{4'd10, 4'b1000, 4'b0001, 4'b0001, 4'hA, 1'b1}; // GE: N=1, V bypassed to 1
    vt[5] = '{4'd15, 4'b0000, 4'b0000, 4'b0000, 4'hF, 1'b0}; // NV never
    vt[6] = '{4'd13, 4'b1001, 4'b0000, 4'b0000, 4'h6, 1'b0}; // LE: Z=0, N==V
    vt[7] = '{4'd12, 4'b0000, 4'b0000, 4'b0000, 4'h9, 1'b1}; // GT

    rst_n = 1'b0; in_valid = 1'b0; in_cond = 4'd0; in_setmask = 4'h0; in_payload = 32'h0;
    cpsr_flags = 4'h0; wb_setmask = 4'h0; wb_flags = 4'h0; flags_pending = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_exec", out_exec, 0);
    chk("rst_out_setmask", out_setmask, 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_stall_count", stall_count, 0);
    rst_n = 1'b1;

    // table vectors, back to back
    for (int i = 0; i < 8; i++)
      cycle(1'b1, vt[i].cond, vt[i].sm, $urandom, vt[i].cpsr, vt[i].wbm, vt[i].wbf,
            1'b0, 1'b0, 1'b1, vt[i].exp);
    idle();

    // all conds against all effective flag patterns, split between cpsr and bypass
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        wbm  = 4'($urandom_range(0, 15));
        r1   = 4'($urandom_range(0, 15));
        r2   = 4'($urandom_range(0, 15));
        cpsr = (4'(f) & ~wbm) | (r1 & wbm);
        wbf  = (4'(f) & wbm) | (r2 & ~wbm);
        cycle(1'b1, 4'(c), 4'($urandom_range(0, 15)), $urandom, cpsr, wbm, wbf,
              1'b0, 1'b0, ($urandom_range(0, 3) != 0), cond_ref(4'(c), 4'(f)));
      end
    end
    idle();

    // interlock: three stalled cycles, then AL passes the pending writer
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'd1, 4'hF, 32'h1111, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_after_3", stall_count, 16'd3);
    cycle(1'b0, 4'd1, 4'hF, 32'h1112, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd14, 4'hC, 32'h2222, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();

    // backpressure: hold for two cycles, then drain+load with no bubble
    cycle(1'b1, 4'd14, 4'h3, 32'hA0A0_0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 4'd14, 4'h5, 32'hA0A0_0002, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'd14, 4'h5, 32'hA0A0_0002, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'd14, 4'h5, 32'hA0A0_0002, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 4'd0,  4'h7, 32'hA0A0_0003, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    // flush: squashes held result and same-cycle transfer; interlock not counted
    cycle(1'b1, 4'd14, 4'hF, 32'hF1F1_0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'd14, 4'hF, 32'hF1F1_0002, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_setmask", out_setmask, 4'h0);
    cycle(1'b1, 4'd0, 4'hF, 32'hF1F1_0003, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // async reset pulse while holding a result, then transfer right after release
    cycle(1'b1, 4'd14, 4'h9, 32'hBEEF_0001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstpulse_out_valid", out_valid, 0);
    chk("rstpulse_stall", stall_count, 0);
    exp_q.delete();
    m_stall = 16'd0;
    #1 rst_n = 1'b1;
    cycle(1'b1, 4'd14, 4'h6, 32'hBEEF_0002, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
